// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
// The round-robin index helper is kept here so the picker and any future users agree on wrap order.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        BUSY
    } state_t;

    localparam int unsigned SPI_W = 16;
    localparam logic [SPI_W-1:0] ERR_RESP = 16'hFFFF;

    // Candidate index 'off' steps after 'base', wrapping modulo n.
    function automatic int unsigned rr_index(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... (mod NUM_REQ)
// and returns the first active requester.
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] idx_n;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_n  = '0;
        // The last owner (ptr) is visited last, giving it lowest priority.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx   = rr_index(32'(ptr), off, NUM_REQ);
            idx_n = IDX_W'(idx);
            if (!valid && req[idx_n]) begin
                valid  = 1'b1;
                winner = idx_n;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ requesters, one 16-bit transaction per
// grant, round-robin order, with a watchdog that aborts a hung transaction.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SPI_W-1:0] cmd_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done_out,
    output logic                     err,
    output logic [SPI_W-1:0]         resp_out,
    output logic                     snd,
    output logic [SPI_W-1:0]         cmd,
    input  logic                     done,
    input  logic [SPI_W-1:0]         resp,
    input  logic                     SS_n_in,
    output logic [NUM_REQ-1:0]       SS_n_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [SPI_W-1:0]  cmd_q,   cmd_d;
    logic [SPI_W-1:0]  resp_q,  resp_d;
    logic [WD_W-1:0]   wdog_q,  wdog_d;

    logic              fin;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [SPI_W-1:0]  cmd_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd_slice
        assign cmd_arr[g] = cmd_in[g*SPI_W +: SPI_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cmd_q   <= '0;
            resp_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        resp_d  = resp_q;
        wdog_d  = wdog_q;
        snd     = 1'b0;
        fin     = 1'b0;
        err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cmd_d   = cmd_arr[pick_idx];
                    state_d = SEND;
                end
            end
            SEND: begin
                snd     = 1'b1;
                wdog_d  = '0;
                state_d = BUSY;
            end
            BUSY: begin
                wdog_d = wdog_q + WD_W'(1);
                // A real done beats a coincident watchdog expiry.
                if (done) begin
                    resp_d  = resp;
                    fin     = 1'b1;
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else if (wdog_q == WD_LAST) begin
                    resp_d  = ERR_RESP;
                    fin     = 1'b1;
                    err     = 1'b1;
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt      = '0;
        done_out = '0;
        SS_n_out = '1;
        if (state_q != IDLE) begin
            gnt[owner_q]      = 1'b1;
            SS_n_out[owner_q] = SS_n_in;
        end
        if (fin) begin
            done_out[owner_q] = 1'b1;
        end
    end

    assign cmd      = cmd_q;
    assign resp_out = resp_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter with two requesters and a behavioural SPI master.
module tb_spi_bus_arbiter;

    localparam int TO = 64;

    typedef struct {
        int          owner;
        logic [15:0] cmd;
        logic        err;
        int          busy;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] cmd_in = '0;
    logic [1:0]  gnt;
    logic [1:0]  done_out;
    logic        err;
    logic [15:0] resp_out;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;
    logic        SS_n_in;
    logic [1:0]  SS_n_out;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   target[2]   = '{0, 0};
    int   done_cnt[2] = '{0, 0};
    int   master_lat  = 3;
    bit   master_hang = 1'b0;
    bit   resp_pending = 1'b0;
    logic [15:0] resp_exp;
    int   cyc = 0;
    int   snd_cyc = 0;
    int   last_done_cyc = 0;

    spi_bus_arbiter #(
        .NUM_REQ     (2),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .cmd_in   (cmd_in),
        .gnt      (gnt),
        .done_out (done_out),
        .err      (err),
        .resp_out (resp_out),
        .snd      (snd),
        .cmd      (cmd),
        .done     (done),
        .resp     (resp),
        .SS_n_in  (SS_n_in),
        .SS_n_out (SS_n_out)
    );

    always #5 clk = ~clk;

    // Each requester holds req until it has seen as many done_out pulses as it asked for.
    always_comb begin
        for (int i = 0; i < 2; i++) req[i] = (done_cnt[i] < target[i]);
    end

    function automatic logic [15:0] resp_fn(input logic [15:0] c);
        return c ^ 16'h0DA7;
    endfunction

    function automatic logic [1:0] onehot(input int o);
        logic [1:0] r;
        r    = '0;
        r[o] = 1'b1;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int owner, input logic [15:0] c, input logic e,
                            input int busy, input int gap);
        exp_t x;
        x.owner = owner;
        x.cmd   = c;
        x.err   = e;
        x.busy  = busy;
        x.gap   = gap;
        exp_q.push_back(x);
    endtask

    task automatic set_cmd(input int i, input logic [15:0] v);
        cmd_in[i*16 +: 16] = v;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || resp_pending) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_snd(input int budget);
        int n = 0;
        while (!snd && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("snd_seen", snd, 1);
    endtask

    // Behavioural SPI master: drops SS_n, answers after master_lat BUSY cycles
    // unless hung, in which case it waits for the arbiter to abort.
    initial begin
        done    = 1'b0;
        resp    = '0;
        SS_n_in = 1'b1;
        forever begin
            @(negedge clk);
            if (snd) begin
                SS_n_in = 1'b0;
                if (!master_hang) begin
                    repeat (master_lat) @(posedge clk);
                    #1;
                    resp = resp_fn(cmd);
                    done = 1'b1;
                    @(posedge clk);
                    #1;
                    done    = 1'b0;
                    SS_n_in = 1'b1;
                end else begin
                    for (int k = 0; k < TO + 8 && done_out == 2'b00; k++) @(negedge clk);
                    @(posedge clk);
                    #1;
                    SS_n_in = 1'b1;
                end
            end
        end
    end

    // Output monitor: checks grants against the queue head, pops on done_out.
    initial begin
        exp_t cur;
        logic [1:0] ssn_exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (resp_pending) begin
                check_eq("resp_out", resp_out, resp_exp);
                check_eq("idle_gnt", gnt, 2'b00);
                check_eq("idle_snd", snd, 0);
                check_eq("idle_ssn", SS_n_out, 2'b11);
                resp_pending = 1'b0;
            end
            if (snd) begin
                if (exp_q.size() == 0) begin
                    check_eq("snd_unexpected", snd, 0);
                end else begin
                    cur = exp_q[0];
                    check_eq("snd_gnt", gnt, onehot(cur.owner));
                    check_eq("snd_cmd", cmd, cur.cmd);
                    if (cur.gap > 0) check_eq("snd_gap", cyc - last_done_cyc, cur.gap);
                    snd_cyc = cyc;
                end
            end
            if (done_out != 2'b00) begin
                for (int i = 0; i < 2; i++) if (done_out[i]) done_cnt[i]++;
                if (exp_q.size() == 0) begin
                    check_eq("done_unexpected", done_out, 0);
                end else begin
                    cur = exp_q.pop_front();
                    ssn_exp = ~onehot(cur.owner);
                    check_eq("done_owner", done_out, onehot(cur.owner));
                    check_eq("done_err", err, cur.err);
                    check_eq("done_ssn", SS_n_out, ssn_exp);
                    check_eq("busy_cycles", cyc - snd_cyc, cur.busy);
                    resp_exp      = cur.err ? 16'hFFFF : resp_fn(cur.cmd);
                    resp_pending  = 1'b1;
                    last_done_cyc = cyc;
                end
            end else begin
                check_eq("err_nodone", err, 0);
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_done_out", done_out, 2'b00);
        check_eq("rst_err", err, 0);
        check_eq("rst_snd", snd, 0);
        check_eq("rst_cmd", cmd, 16'h0000);
        check_eq("rst_resp_out", resp_out, 16'h0000);
        check_eq("rst_ssn", SS_n_out, 2'b11);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single transaction from requester 0; cmd_in changed after grant.
        set_cmd(0, 16'h0D02);
        master_lat = 3;
        push_exp(0, 16'h0D02, 1'b0, 3, 0);
        target[0] = target[0] + 1;
        @(negedge clk);
        check_eq("t1_snd_latency", snd, 1);
        check_eq("t1_gnt", gnt, 2'b01);
        set_cmd(0, 16'hBEEF);
        @(negedge clk);
        check_eq("t1_cmd_latched", cmd, 16'h0D02);
        check_eq("t1_ssn1_idle", SS_n_out[1], 1);
        wait_drain(50);

        // Both requesting continuously: last owner was 0, so 1,0,1,0.
        master_lat = 1;
        set_cmd(0, 16'h1111);
        set_cmd(1, 16'h2222);
        push_exp(1, 16'h2222, 1'b0, 1, 0);
        push_exp(0, 16'h1111, 1'b0, 1, 2);
        push_exp(1, 16'h2222, 1'b0, 1, 2);
        push_exp(0, 16'h1111, 1'b0, 1, 2);
        target[0] = target[0] + 2;
        target[1] = target[1] + 2;
        wait_drain(100);

        // Sole requester 1 is re-granted with one IDLE cycle between.
        master_lat = 2;
        set_cmd(1, 16'h3C3C);
        push_exp(1, 16'h3C3C, 1'b0, 2, 0);
        push_exp(1, 16'h3C3C, 1'b0, 2, 2);
        push_exp(1, 16'h3C3C, 1'b0, 2, 2);
        target[1] = target[1] + 3;
        wait_drain(100);

        // Hung master: watchdog aborts owner 0, pending requester 1 follows.
        master_hang = 1'b1;
        set_cmd(0, 16'h4444);
        push_exp(0, 16'h4444, 1'b1, TO, 0);
        target[0] = target[0] + 1;
        wait_snd(5);
        repeat (5) @(negedge clk);
        set_cmd(1, 16'h5555);
        push_exp(1, 16'h5555, 1'b0, 2, 2);
        target[1] = target[1] + 1;
        master_hang = 1'b0;
        wait_drain(TO + 50);

        // Done one cycle before, then exactly at, watchdog expiry.
        master_lat = TO - 1;
        set_cmd(0, 16'h5A5A);
        push_exp(0, 16'h5A5A, 1'b0, TO - 1, 0);
        target[0] = target[0] + 1;
        wait_drain(TO + 50);
        master_lat = TO;
        set_cmd(0, 16'hA5A5);
        push_exp(0, 16'hA5A5, 1'b0, TO, 0);
        target[0] = target[0] + 1;
        wait_drain(TO + 50);

        // Async reset mid-BUSY; afterwards requester 0 must win first.
        master_lat = 20;
        set_cmd(0, 16'h6006);
        set_cmd(1, 16'h7117);
        push_exp(1, 16'h7117, 1'b0, 20, 0);
        target[0] = target[0] + 1;
        target[1] = target[1] + 1;
        wait_snd(5);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_gnt", gnt, 2'b00);
        check_eq("t6_snd", snd, 0);
        check_eq("t6_ssn", SS_n_out, 2'b11);
        check_eq("t6_done_out", done_out, 2'b00);
        check_eq("t6_cmd", cmd, 16'h0000);
        check_eq("t6_resp_out", resp_out, 16'h0000);
        exp_q.delete();
        master_lat = 2;
        push_exp(0, 16'h6006, 1'b0, 2, 0);
        push_exp(1, 16'h7117, 1'b0, 2, 2);
        repeat (25) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
